cve2_sim_bus_arb: RTL and testbench
===================================

// Module: cve2_sim_bus_arb
// PURPOSE
//  Parametrised N-host/M-device simulation interconnect for the compliance and simple-system benches.
//  Successor to the fixed-priority single-outstanding bus: adds selectable round-robin arbitration,
//  up to MaxOutstanding pipelined requests with in-order response routing, and internal error
//  responses for unmapped addresses. Sits between core I/D ports, test-util hosts and RAM/peripherals.
// PARAMETERS
//  NrHosts         3   number of bus hosts (>=1); index 0 = highest fixed priority
//  NrDevices       2   number of devices (>=1)
//  DataWidth      32   data bus width (multiple of 8)
//  AddressWidth   32   address width
//  ArbMode         0   0 = fixed priority (lowest index wins), 1 = round-robin
//  MaxOutstanding  2   response-tracking FIFO depth (>=1)
// PORTS
//  clk_i                   in   1                 clock
//  rst_i                   in   1                 reset, synchronous, active-high
//  host_req_i              in   NrHosts           request per host
//  host_gnt_o              out  NrHosts           grant, one-hot or zero
//  host_addr_i/host_we_i   in   NrHosts*AW / NrHosts   packed per-host address / write enable
//  host_be_i/host_wdata_i  in   NrHosts*DW/8 / NrHosts*DW  packed byte enables / write data
//  host_rvalid_o           out  NrHosts           response valid, one-hot or zero
//  host_rdata_o            out  DW                response data (shared, qualified by rvalid)
//  host_err_o              out  NrHosts           response error, valid with rvalid
//  device_req_o            out  NrDevices         request per device, one-hot or zero
//  device_addr_o/we_o/be_o/wdata_o  out  AW/1/DW/8/DW  shared request fields of granted host
//  device_rvalid_i/err_i   in   NrDevices         response valid / error per device
//  device_rdata_i          in   NrDevices*DW      packed response data
//  cfg_device_addr_base_i  in   NrDevices*AW      device base addresses
//  cfg_device_addr_mask_i  in   NrDevices*AW      device address masks
// BEHAVIOUR
//  - Decode: device d matches if (addr & mask[d]) == base[d]; lowest matching d wins; none = UNMAPPED.
//  - Arbitration (combinational, same cycle): candidate = winner among host_req_i. ArbMode0: lowest
//    index. ArbMode1: first requester at/after rr_ptr (wrapping); rr_ptr <= winner+1 (mod NrHosts)
//    only on an actual grant.
//  - Issue allowed iff FIFO count < MaxOutstanding AND (FIFO empty OR candidate target == target of
//    most recently issued entry). If blocked: no grant to anyone this cycle, rr_ptr unchanged.
//  - On issue: host_gnt_o[winner]=1; device_req_o[target]=1 (none if UNMAPPED); device fields muxed
//    from winner; push {host, target} into FIFO. Device fields are don't-care without a grant.
//  - Response (head entry): mapped -> pop on device_rvalid_i[head.dev]; host_rvalid_o[head.host]=1,
//    host_rdata_o=device_rdata[head.dev], host_err_o=device_err_i[head.dev]. UNMAPPED -> pops in
//    first cycle it is head (>=1 cycle after issue), err=1, rdata=0. Zero-latency devices unsupported.
//  - Push and pop in same cycle permitted; full check uses registered count (no push when full
//    even if popping). Count width clog2(MaxOutstanding+1); FIFO pointers wrap mod MaxOutstanding.
//  - Device rvalid when FIFO empty or from non-head device: ignored; sim assertion fires.
//  - Reset: FIFO empty, rr_ptr=0, host_gnt_o/device_req_o/host_rvalid_o/host_err_o=0, rdata=0;
//    grant suppressed while rst_i=1. Reset mid-operation discards outstanding entries; late device
//    responses after reset are dropped by the empty-FIFO rule.
// TESTING
//  1. ArbMode0, hosts 0 and 2 req RAM same cycle -> gnt=3'b001, then 3'b100 next cycle; rvalids to 0 then 2.
//  2. ArbMode1, hosts 0,1,2 req continuously, 1-cycle RAM -> grant order 0,1,2,0,1,2.
//  3. Host1 reads 0x0003_0000 (unmapped) -> no device_req; next cycle rvalid[1]=1, err[1]=1, rdata=0.
//  4. Host1 RAM read outstanding (3-cycle latency), host0 req 0x2_0000 -> host0 stalled until RAM pop.
//  5. MaxOutstanding=2, latency 4, 3 back-to-back RAM reqs -> 3rd granted only in cycle after 1st pop.
//  6. rst_i asserted with 2 entries outstanding, device rvalid one cycle later -> no host_rvalid_o.

Source files
------------

// File: rtl/cve2_sim_bus_arb_if.sv
// cve2_sim_bus_arb_if: host/device bus bundle for the simulation interconnect
// Host side : req/gnt handshake, packed per-host addr/we/be/wdata, rvalid/err one-hot, shared rdata
// Device side: one-hot req, shared addr/we/be/wdata, per-device rvalid/err, packed rdata
// Config    : packed per-device base address and mask used for decode
// Modports  : slave = interconnect, master = environment (hosts, devices, config)
interface cve2_sim_bus_arb_if #(
   parameter int NrHosts      = 3,
   parameter int NrDevices    = 2,
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32
);
   logic [NrHosts-1:0]                host_req;
   logic [NrHosts-1:0]                host_gnt;
   logic [NrHosts*AddressWidth-1:0]   host_addr;
   logic [NrHosts-1:0]                host_we;
   logic [NrHosts*DataWidth/8-1:0]    host_be;
   logic [NrHosts*DataWidth-1:0]      host_wdata;
   logic [NrHosts-1:0]                host_rvalid;
   logic [DataWidth-1:0]              host_rdata;
   logic [NrHosts-1:0]                host_err;
   logic [NrDevices-1:0]              device_req;
   logic [AddressWidth-1:0]           device_addr;
   logic                              device_we;
   logic [DataWidth/8-1:0]            device_be;
   logic [DataWidth-1:0]              device_wdata;
   logic [NrDevices-1:0]              device_rvalid;
   logic [NrDevices*DataWidth-1:0]    device_rdata;
   logic [NrDevices-1:0]              device_err;
   logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base;
   logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask;

   modport slave (
      input  host_req, host_addr, host_we, host_be, host_wdata,
      input  device_rvalid, device_rdata, device_err,
      input  cfg_device_addr_base, cfg_device_addr_mask,
      output host_gnt, host_rvalid, host_rdata, host_err,
      output device_req, device_addr, device_we, device_be, device_wdata
   );

   modport master (
      output host_req, host_addr, host_we, host_be, host_wdata,
      output device_rvalid, device_rdata, device_err,
      output cfg_device_addr_base, cfg_device_addr_mask,
      input  host_gnt, host_rvalid, host_rdata, host_err,
      input  device_req, device_addr, device_we, device_be, device_wdata
   );
endinterface

// File: rtl/cve2_sim_bus_arb.sv
// cve2_sim_bus_arb: N-host/M-device simulation interconnect with pipelined in-order responses
// clk_i : clock
// rst_i : synchronous active-high reset; clears the response FIFO and rr pointer, blocks grants
// bus   : slave side of cve2_sim_bus_arb_if (host handshake, device request/response, decode config)
// Grants are combinational in the request cycle; responses return to hosts in issue order.
// Unmapped addresses get an internal error response the first cycle their entry is at the head.
module cve2_sim_bus_arb #(
   parameter int NrHosts        = 3,
   parameter int NrDevices      = 2,
   parameter int DataWidth      = 32,
   parameter int AddressWidth   = 32,
   parameter int ArbMode        = 0,
   parameter int MaxOutstanding = 2
) (
   input logic               clk_i,
   input logic               rst_i,
   cve2_sim_bus_arb_if.slave bus
);
   localparam int HostW = NrHosts > 1 ? $clog2(NrHosts) : 1;
   localparam int DevW  = NrDevices > 1 ? $clog2(NrDevices) : 1;
   localparam int PtrW  = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
   localparam int CntW  = $clog2(MaxOutstanding + 1);
   localparam int BeW   = DataWidth / 8;

   logic [HostW-1:0]        rr_ptr;
   logic [HostW-1:0]        win;
   logic                    win_valid;
   logic [AddressWidth-1:0] win_addr;
   logic [DevW-1:0]         tgt;
   logic                    tgt_map;
   logic                    issue;
   logic                    pop;
   logic [DevW-1:0]         last_dev;
   logic                    last_map;
   logic [HostW-1:0]        fifo_host [MaxOutstanding];
   logic [DevW-1:0]         fifo_dev [MaxOutstanding];
   logic                    fifo_map [MaxOutstanding];
   logic [PtrW-1:0]         wr_ptr;
   logic [PtrW-1:0]         rd_ptr;
   logic [CntW-1:0]         cnt;
   logic [HostW-1:0]        head_host;
   logic [DevW-1:0]         head_dev;
   logic                    head_map;
   logic [NrDevices-1:0]    rv_ok;

   // Candidate selection: scanning from the far end down lets the nearest requester win.
   // In round-robin mode the scan starts at rr_ptr and wraps.
   always_comb begin
      int h;
      h = 0;
      win = '0;
      win_valid = 1'b0;
      for (int i = NrHosts - 1; i >= 0; i--) begin
         h = ArbMode == 1 ? (int'(rr_ptr) + i) % NrHosts : i;
         if (bus.host_req[h]) begin
            win = HostW'(h);
            win_valid = 1'b1;
         end
      end
   end

   // Address decode of the candidate only; lowest matching device wins.
   always_comb begin
      win_addr = bus.host_addr[int'(win)*AddressWidth +: AddressWidth];
      tgt = '0;
      tgt_map = 1'b0;
      for (int d = NrDevices - 1; d >= 0; d--) begin
         if ((win_addr & bus.cfg_device_addr_mask[d*AddressWidth +: AddressWidth]) ==
             bus.cfg_device_addr_base[d*AddressWidth +: AddressWidth]) begin
            tgt = DevW'(d);
            tgt_map = 1'b1;
         end
      end
   end

   // Only one target may be in flight at a time so responses cannot overtake each other.
   // Unmapped entries store tgt = 0, so comparing {map, dev} treats UNMAPPED as its own target.
   always_comb begin
      head_host = fifo_host[rd_ptr];
      head_dev  = fifo_dev[rd_ptr];
      head_map  = fifo_map[rd_ptr];
      issue = win_valid && !rst_i && int'(cnt) < MaxOutstanding &&
              (cnt == '0 || {tgt_map, tgt} == {last_map, last_dev});
      pop = !rst_i && cnt != '0 && (head_map ? bus.device_rvalid[head_dev] : 1'b1);
   end

   always_comb begin
      bus.host_gnt = '0;
      bus.host_gnt[win] = issue;
      bus.device_req = '0;
      bus.device_req[tgt] = issue && tgt_map;
      bus.device_addr = win_addr;
      bus.device_we = bus.host_we[win];
      bus.device_be = bus.host_be[int'(win)*BeW +: BeW];
      bus.device_wdata = bus.host_wdata[int'(win)*DataWidth +: DataWidth];
   end

   always_comb begin
      bus.host_rvalid = '0;
      bus.host_rvalid[head_host] = pop;
      bus.host_err = '0;
      bus.host_err[head_host] = pop && (!head_map || bus.device_err[head_dev]);
      bus.host_rdata = pop && head_map ? bus.device_rdata[int'(head_dev)*DataWidth +: DataWidth] : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr   <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         last_dev <= '0;
         last_map <= 1'b0;
      end else begin
         if (issue) begin
            fifo_host[wr_ptr] <= win;
            fifo_dev[wr_ptr]  <= tgt;
            fifo_map[wr_ptr]  <= tgt_map;
            wr_ptr   <= wr_ptr == PtrW'(MaxOutstanding - 1) ? '0 : wr_ptr + PtrW'(1);
            last_dev <= tgt;
            last_map <= tgt_map;
            rr_ptr   <= win == HostW'(NrHosts - 1) ? '0 : win + HostW'(1);
         end
         if (pop) rd_ptr <= rd_ptr == PtrW'(MaxOutstanding - 1) ? '0 : rd_ptr + PtrW'(1);
         cnt <= cnt + CntW'(issue) - CntW'(pop);
      end
   end

   // A device may only answer when its request is the oldest outstanding one.
   always_comb begin
      rv_ok = '0;
      rv_ok[head_dev] = cnt != '0 && head_map;
   end

   a_rvalid_in_order: assert property (@(posedge clk_i) disable iff (rst_i)
      (bus.device_rvalid & ~rv_ok) == '0);
endmodule

// File: tb/tb_cve2_sim_bus_arb.sv
// tb_cve2_sim_bus_arb: scoreboard bench for the fixed-priority and round-robin interconnect variants
module tb_cve2_sim_bus_arb;
   localparam int NH = 3;
   localparam int ND = 2;
   localparam int DW = 32;
   localparam int AW = 32;

   typedef struct packed {
      logic [1:0]    host;
      logic          err;
      logic [DW-1:0] rdata;
   } exp_t;

   typedef struct packed {
      logic [31:0]   due;
      logic [AW-1:0] adr;
   } pend_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NH-1:0]      h_req [2];
   logic [NH*AW-1:0]   h_addr;
   logic [NH-1:0]      h_we;
   logic [NH*DW/8-1:0] h_be;
   logic [NH*DW-1:0]   h_wdata;
   logic [ND-1:0]      d_rv [2];
   logic [ND-1:0]      d_err [2];
   logic [ND*DW-1:0]   d_rdata [2];

   logic [NH-1:0]   o_gnt [2];
   logic [NH-1:0]   o_rv [2];
   logic [NH-1:0]   o_err [2];
   logic [DW-1:0]   o_rdata [2];
   logic [ND-1:0]   o_dreq [2];
   logic [AW-1:0]   o_daddr [2];
   logic            o_dwe [2];
   logic [DW-1:0]   o_dwdata [2];

   localparam logic [ND*AW-1:0] BASE = {32'h0002_0000, 32'h0001_0000};
   localparam logic [ND*AW-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_0000};

   cve2_sim_bus_arb_if #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW)) bf ();
   cve2_sim_bus_arb_if #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW)) br ();

   cve2_sim_bus_arb #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW),
                      .ArbMode(0), .MaxOutstanding(2)) dut_fp (.clk_i(clk), .rst_i(rst), .bus(bf));
   cve2_sim_bus_arb #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW),
                      .ArbMode(1), .MaxOutstanding(2)) dut_rr (.clk_i(clk), .rst_i(rst), .bus(br));

   assign bf.host_req = h_req[0];
   assign bf.host_addr = h_addr;
   assign bf.host_we = h_we;
   assign bf.host_be = h_be;
   assign bf.host_wdata = h_wdata;
   assign bf.device_rvalid = d_rv[0];
   assign bf.device_err = d_err[0];
   assign bf.device_rdata = d_rdata[0];
   assign bf.cfg_device_addr_base = BASE;
   assign bf.cfg_device_addr_mask = MASK;
   assign br.host_req = h_req[1];
   assign br.host_addr = h_addr;
   assign br.host_we = h_we;
   assign br.host_be = h_be;
   assign br.host_wdata = h_wdata;
   assign br.device_rvalid = d_rv[1];
   assign br.device_err = d_err[1];
   assign br.device_rdata = d_rdata[1];
   assign br.cfg_device_addr_base = BASE;
   assign br.cfg_device_addr_mask = MASK;

   assign o_gnt[0] = bf.host_gnt;
   assign o_rv[0] = bf.host_rvalid;
   assign o_err[0] = bf.host_err;
   assign o_rdata[0] = bf.host_rdata;
   assign o_dreq[0] = bf.device_req;
   assign o_daddr[0] = bf.device_addr;
   assign o_dwe[0] = bf.device_we;
   assign o_dwdata[0] = bf.device_wdata;
   assign o_gnt[1] = br.host_gnt;
   assign o_rv[1] = br.host_rvalid;
   assign o_err[1] = br.host_err;
   assign o_rdata[1] = br.host_rdata;
   assign o_dreq[1] = br.device_req;
   assign o_daddr[1] = br.device_addr;
   assign o_dwe[1] = br.device_we;
   assign o_dwdata[1] = br.device_wdata;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int lat [ND];
   exp_t sb [2][$];
   pend_t dq [2][ND][$];
   logic [2:0] rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory map as seen by the bench: 0x0001_xxxx -> device 0, 0x0002_xxxx -> device 1.
   function automatic int dev_of(input logic [AW-1:0] a);
      return a[31:16] == 16'h0001 ? 0 : a[31:16] == 16'h0002 ? 1 : -1;
   endfunction

   function automatic logic [DW-1:0] dev_data(input int d, input logic [AW-1:0] a);
      return a ^ (d == 0 ? 32'h5A5A_0000 : 32'h0F0F_0000);
   endfunction

   // Device models: respond in order, lat[d] cycles after the request cycle; device 1 always errors.
   initial begin
      pend_t p;
      for (int k = 0; k < 2; k++) begin
         d_rv[k] = '0;
         d_err[k] = 2'b10;
         d_rdata[k] = '0;
      end
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         for (int k = 0; k < 2; k++) begin
            for (int d = 0; d < ND; d++) begin
               d_rv[k][d] = 1'b0;
               if (dq[k][d].size() != 0 && dq[k][d][0].due == 32'(cyc)) begin
                  p = dq[k][d].pop_front();
                  d_rv[k][d] = 1'b1;
                  d_rdata[k][d*DW +: DW] = dev_data(d, p.adr);
               end
            end
         end
      end
   end

   // Monitor: responses are checked against the scoreboard before this cycle's grant is pushed.
   initial begin
      exp_t e;
      int h;
      int dv;
      logic [AW-1:0] a;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (rst) begin
               check("rst_gnt", o_gnt[k], 0);
               check("rst_rvalid", o_rv[k], 0);
               check("rst_err", o_err[k], 0);
               check("rst_rdata", o_rdata[k], 0);
               check("rst_dreq", o_dreq[k], 0);
               sb[k].delete();
            end else begin
               if (o_rv[k] != 0) begin
                  if (sb[k].size() == 0) check("rv_unexpected", o_rv[k], 0);
                  else begin
                     e = sb[k].pop_front();
                     check("rv_host", o_rv[k], 1 << e.host);
                     check("rv_err", o_err[k], e.err ? 1 << e.host : 0);
                     check("rv_rdata", o_rdata[k], e.rdata);
                  end
               end
               if (o_gnt[k] != 0) begin
                  check("gnt_onehot", $countones(o_gnt[k]), 1);
                  h = 0;
                  for (int i = 0; i < NH; i++) if (o_gnt[k][i]) h = i;
                  a = h_addr[h*AW +: AW];
                  dv = dev_of(a);
                  check("dreq", o_dreq[k], dv < 0 ? 0 : 1 << dv);
                  check("daddr", o_daddr[k], a);
                  check("dwe", o_dwe[k], h_we[h]);
                  check("dwdata", o_dwdata[k], h_wdata[h*DW +: DW]);
                  e.host = 2'(h);
                  e.err = dv != 0;
                  e.rdata = dv < 0 ? '0 : dev_data(dv, a);
                  sb[k].push_back(e);
               end
            end
            for (int d = 0; d < ND; d++)
               if (o_dreq[k][d]) dq[k][d].push_back('{due: 32'(cyc + lat[d]), adr: o_daddr[k]});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic gchk(input int k, input logic [NH-1:0] exp, input string tag);
      @(negedge clk);
      check(tag, o_gnt[k], exp);
      step();
   endtask

   task automatic set_addr(input int h, input logic [AW-1:0] a);
      h_addr[h*AW +: AW] = a;
   endtask

   initial begin
      rst = 1'b1;
      h_req[0] = '0;
      h_req[1] = '0;
      h_addr = '0;
      h_we = 3'b010;
      h_be = '1;
      h_wdata = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
      lat[0] = 1;
      lat[1] = 2;
      idle(3);
      rst = 1'b0;
      // fixed priority: simultaneous requests
      set_addr(0, 32'h0001_0010);
      set_addr(2, 32'h0001_0020);
      h_req[0] = 3'b101;
      gchk(0, 3'b001, "t1_first");
      h_req[0] = 3'b100;
      gchk(0, 3'b100, "t1_second");
      h_req[0] = '0;
      idle(4);
      // round robin with continuous requests
      set_addr(0, 32'h0001_0100);
      set_addr(1, 32'h0001_0104);
      set_addr(2, 32'h0001_0108);
      h_req[1] = 3'b111;
      for (int i = 0; i < 6; i++) gchk(1, rr_exp[i], "t2_rr_order");
      h_req[1] = '0;
      idle(4);
      // unmapped address
      set_addr(1, 32'h0003_0000);
      h_req[0] = 3'b010;
      @(negedge clk);
      check("t3_gnt", o_gnt[0], 3'b010);
      check("t3_dreq", o_dreq[0], 0);
      step();
      h_req[0] = '0;
      @(negedge clk);
      check("t3_rvalid", o_rv[0], 3'b010);
      check("t3_err", o_err[0], 3'b010);
      check("t3_rdata", o_rdata[0], 0);
      step();
      idle(2);
      // different target stalls until the outstanding RAM read pops
      lat[0] = 3;
      set_addr(1, 32'h0001_0040);
      set_addr(0, 32'h0002_0000);
      h_req[0] = 3'b010;
      gchk(0, 3'b010, "t4_ram_gnt");
      h_req[0] = 3'b001;
      gchk(0, 3'b000, "t4_stall");
      gchk(0, 3'b000, "t4_stall");
      @(negedge clk);
      check("t4_pop_gnt", o_gnt[0], 0);
      check("t4_pop_rvalid", o_rv[0], 3'b010);
      step();
      gchk(0, 3'b001, "t4_dev1_gnt");
      h_req[0] = '0;
      idle(5);
      // FIFO full with MaxOutstanding = 2
      lat[0] = 4;
      set_addr(0, 32'h0001_0200);
      set_addr(1, 32'h0001_0204);
      set_addr(2, 32'h0001_0208);
      h_req[0] = 3'b111;
      gchk(0, 3'b001, "t5_g0");
      h_req[0] = 3'b110;
      gchk(0, 3'b010, "t5_g1");
      h_req[0] = 3'b100;
      repeat (3) gchk(0, 3'b000, "t5_full");
      gchk(0, 3'b100, "t5_g2");
      h_req[0] = '0;
      idle(8);
      // reset with two entries outstanding; late device responses must be dropped
      set_addr(0, 32'h0001_0300);
      set_addr(1, 32'h0001_0304);
      h_req[0] = 3'b011;
      gchk(0, 3'b001, "t6_g0");
      h_req[0] = 3'b010;
      gchk(0, 3'b010, "t6_g1");
      h_req[0] = '0;
      step();
      rst = 1'b1;
      set_addr(2, 32'h0003_0000);
      h_req[0] = 3'b100;
      idle(4);
      rst = 1'b0;
      @(negedge clk);
      check("t6_post_gnt", o_gnt[0], 3'b100);
      step();
      h_req[0] = '0;
      @(negedge clk);
      check("t6_post_rvalid", o_rv[0], 3'b100);
      check("t6_post_err", o_err[0], 3'b100);
      step();
      idle(3);
      for (int k = 0; k < 2; k++) check("sb_drain", sb[k].size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
